vend_ctrl: RTL

- Sequencing controller for the drink vending datapath: accumulates coin credit, validates selections against a fixed price table, and drives a dispense handshake to the drink motor.
- Returns change through a coin hopper handshake using greedy denominations.
- Sits between coin acceptor/keypad front end and the dispense/hopper actuators.
- Owns the single credit register; no other block modifies credit.

---
 rtl/vend_pkg.sv | 48 ++++
 rtl/vend_ack_timer.sv | 44 ++++
 rtl/vend_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and lookup helpers for the vending controller: FSM states,
// drink ids, the fixed price table and the change-hopper denominations.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DISP   = 2'd1,
        ST_CHANGE = 2'd2
    } state_e;

    localparam int PRICE_W = 8;

    localparam logic [2:0] ID_TEA    = 3'd1;
    localparam logic [2:0] ID_COKE   = 3'd2;
    localparam logic [2:0] ID_COFFEE = 3'd3;
    localparam logic [2:0] ID_MILK   = 3'd4;

    localparam logic [1:0] DEN_1  = 2'd0;
    localparam logic [1:0] DEN_5  = 2'd1;
    localparam logic [1:0] DEN_10 = 2'd2;

    // A zero price marks an id that does not name a drink.
    function automatic logic [PRICE_W-1:0] price_of(input logic [2:0] id);
        case (id)
            ID_TEA:    price_of = 8'd10;
            ID_COKE:   price_of = 8'd15;
            ID_COFFEE: price_of = 8'd20;
            ID_MILK:   price_of = 8'd25;
            default:   price_of = 8'd0;
        endcase
    endfunction

    function automatic logic [PRICE_W-1:0] denom_value(input logic [1:0] code);
        case (code)
            DEN_10:  denom_value = 8'd10;
            DEN_5:   denom_value = 8'd5;
            default: denom_value = 8'd1;
        endcase
    endfunction

    // Greedy pick: the largest coin that still fits in the remaining amount.
    function automatic logic [1:0] denom_code(input logic [31:0] amount);
        if (amount >= 32'd10)     denom_code = DEN_10;
        else if (amount >= 32'd5) denom_code = DEN_5;
        else                      denom_code = DEN_1;
    endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// Acknowledge watchdog shared by dispense and change phases: load restarts
// the count, expire pulses once when ACK_TIMEOUT cycles pass without clear.
module vend_ack_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    // Count 0 is the cycle the request first becomes visible.
    assign expire = run_q && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            cnt_d = '0;
            run_d = 1'b1;
        end else if (clear || expire) begin
            run_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending sequencer: owns the credit register, accepts coins and selections,
// runs the dispense handshake and pays change one greedy coin at a time.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 8,
    parameter int MAX_CREDIT  = 99,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_val,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [2:0]          sel_id,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                sel_err,
    output logic                disp_req,
    output logic [2:0]          disp_id,
    input  logic                disp_ack,
    output logic                chg_req,
    output logic [1:0]          chg_coin,
    input  logic                chg_ack,
    output logic                busy,
    output logic                fault
);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [2:0]          disp_id_q, disp_id_d;
    logic                fault_q, fault_d;
    logic                disp_req_q, disp_req_d;
    logic                chg_req_q, chg_req_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_err_q, sel_err_d;

    logic                tmr_load, tmr_clear, tmr_expire;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] sel_price, chg_value;
    logic [1:0]          chg_code;
    logic                coin_blocked;

    vend_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .clear  (tmr_clear),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        price_d       = price_q;
        disp_id_d     = disp_id_q;
        fault_d       = fault_q;
        disp_req_d    = disp_req_q;
        chg_req_d     = chg_req_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        tmr_load      = 1'b0;
        tmr_clear     = 1'b0;
        coin_blocked  = 1'b0;
        coin_sum      = {1'b0, credit_q} + {1'b0, coin_val};
        sel_price     = CREDIT_W'(price_of(sel_id));
        chg_code      = denom_code(32'(credit_q));
        chg_value     = CREDIT_W'(denom_value(chg_code));

        case (state_q)
            ST_IDLE: begin
                if (cancel && credit_q != '0) begin
                    state_d      = ST_CHANGE;
                    chg_req_d    = 1'b1;
                    tmr_load     = 1'b1;
                    coin_blocked = 1'b1;
                end else if (sel_valid) begin
                    if (sel_price == '0 || credit_q < sel_price || fault_q) begin
                        sel_err_d = 1'b1;
                    end else begin
                        credit_d     = credit_q - sel_price;
                        price_d      = sel_price;
                        disp_id_d    = sel_id;
                        disp_req_d   = 1'b1;
                        state_d      = ST_DISP;
                        tmr_load     = 1'b1;
                        coin_blocked = 1'b1;
                    end
                end
                // Sum is one bit wider so a large coin cannot wrap past the ceiling.
                if (coin_valid) begin
                    if (coin_blocked || coin_sum > (CREDIT_W + 1)'(MAX_CREDIT))
                        coin_reject_d = 1'b1;
                    else
                        credit_d = coin_sum[CREDIT_W-1:0];
                end
            end

            ST_DISP: begin
                coin_reject_d = coin_valid;
                sel_err_d     = sel_valid;
                if (disp_ack) begin
                    disp_req_d = 1'b0;
                    disp_id_d  = '0;
                    tmr_clear  = 1'b1;
                    if (credit_q != '0) begin
                        state_d   = ST_CHANGE;
                        chg_req_d = 1'b1;
                        tmr_load  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmr_expire) begin
                    // Motor never answered: give the price back and pay it out.
                    credit_d   = credit_q + price_q;
                    fault_d    = 1'b1;
                    disp_req_d = 1'b0;
                    disp_id_d  = '0;
                    state_d    = ST_CHANGE;
                    chg_req_d  = 1'b1;
                    tmr_load   = 1'b1;
                end
            end

            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                sel_err_d     = sel_valid;
                if (chg_req_q) begin
                    if (chg_ack) begin
                        credit_d  = credit_q - chg_value;
                        chg_req_d = 1'b0;
                        tmr_clear = 1'b1;
                        if (credit_q == chg_value)
                            state_d = ST_IDLE;
                    end else if (tmr_expire) begin
                        fault_d   = 1'b1;
                        chg_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    chg_req_d = 1'b1;
                    tmr_load  = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            price_q       <= '0;
            disp_id_q     <= '0;
            fault_q       <= 1'b0;
            disp_req_q    <= 1'b0;
            chg_req_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            price_q       <= price_d;
            disp_id_q     <= disp_id_d;
            fault_q       <= fault_d;
            disp_req_q    <= disp_req_d;
            chg_req_q     <= chg_req_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
        end
    end

    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_err     = sel_err_q;
    assign disp_req    = disp_req_q;
    assign disp_id     = disp_id_q;
    assign chg_req     = chg_req_q;
    assign chg_coin    = chg_req_q ? chg_code : 2'd0;
    assign busy        = (state_q != ST_IDLE);
    assign fault       = fault_q;

endmodule
